// File: rtl/mnist_pkg.sv
// Shared types and constants for the MNIST layer sequencer.
package mnist_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LAUNCH,
        WAIT,
        FINISH,
        DONE
    } seq_state_t;

    localparam int NUM_CLASSES_DEF = 10;
    localparam int PRED_W = 16;
    localparam logic [PRED_W-1:0] PRED_ERR = 16'hFFFF;

endpackage

// File: rtl/mnist_argmax_unit.sv
// Streaming signed argmax over the final layer's class scores.
module mnist_argmax_unit
    import mnist_pkg::*;
#(
    parameter int DATA_W      = 16,
    parameter int NUM_CLASSES = NUM_CLASSES_DEF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clear,
    input  logic                     valid,
    input  logic signed [DATA_W-1:0] data,
    output logic        [3:0]        best_idx,
    output logic        [4:0]        count,
    output logic                     overflow
);

    logic signed [DATA_W-1:0] best_val;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            best_val <= '0;
            best_idx <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else if (clear) begin
            best_val <= '0;
            best_idx <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else if (valid) begin
            if (count == 5'(NUM_CLASSES)) begin
                overflow <= 1'b1;
            end else begin
                // strictly greater keeps the lowest index on ties
                if (count == '0 || data > best_val) begin
                    best_val <= data;
                    best_idx <= count[3:0];
                end
                count <= count + 5'd1;
            end
        end
    end

endmodule

// File: rtl/mnist_layer_sequencer.sv
// Launches each layer engine in turn, then argmaxes the final scores.
// Optional per-layer timeout: define SEQ_WATCHDOG_EN.
module mnist_layer_sequencer
    import mnist_pkg::*;
#(
    parameter int NUM_LAYERS  = 3,
    parameter int NUM_CLASSES = NUM_CLASSES_DEF,
    parameter int DATA_W      = 16,
    parameter int WDOG_CYC    = 1000000
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    output logic [NUM_LAYERS-1:0]    layer_start,
    input  logic [NUM_LAYERS-1:0]    layer_done,
    input  logic                     score_valid,
    input  logic signed [DATA_W-1:0] score_data,
    output logic                     busy,
    output logic                     done,
    output logic [PRED_W-1:0]        final_prediction,
    output logic                     err
);

    localparam int KW = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(NUM_LAYERS - 1);

    seq_state_t state, state_nx;
    logic [KW-1:0] k, k_nx;
    logic [NUM_LAYERS-1:0] layer_start_nx;
    logic busy_nx, done_nx, err_nx;
    logic [PRED_W-1:0] pred_nx;
    logic arg_clear, arg_valid, mismatch;
    logic timeout, wdog_flag;
    logic [3:0] best_idx;
    logic [4:0] count;
    logic overflow;

    assign arg_clear = (state_nx == LAUNCH);
    assign arg_valid = score_valid && (state == WAIT) && (k == K_LAST);
    assign mismatch  = overflow || (count != 5'(NUM_CLASSES));

    mnist_argmax_unit #(
        .DATA_W     (DATA_W),
        .NUM_CLASSES(NUM_CLASSES)
    ) u_argmax (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (arg_clear),
        .valid   (arg_valid),
        .data    (score_data),
        .best_idx(best_idx),
        .count   (count),
        .overflow(overflow)
    );

`ifdef SEQ_WATCHDOG_EN
    localparam int WW = $clog2(WDOG_CYC + 1);
    logic [WW-1:0] wdog_cnt;

    assign timeout = (state == WAIT) && !layer_done[k]
                  && (wdog_cnt == WW'(WDOG_CYC - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wdog_cnt  <= '0;
            wdog_flag <= 1'b0;
        end else begin
            if (state == LAUNCH)
                wdog_cnt <= '0;
            else if (state == WAIT)
                wdog_cnt <= wdog_cnt + 1'b1;
            if (state_nx == LAUNCH)
                wdog_flag <= 1'b0;
            else if (timeout)
                wdog_flag <= 1'b1;
        end
    end
`else
    wire unused_wdog = ^WDOG_CYC;
    assign timeout   = 1'b0;
    assign wdog_flag = 1'b0;
`endif

    always_comb begin
        state_nx       = state;
        k_nx           = k;
        layer_start_nx = '0;
        busy_nx        = 1'b0;
        done_nx        = done;
        err_nx         = err;
        pred_nx        = final_prediction;
        unique case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_nx = LAUNCH;
                    k_nx     = '0;
                end
            end
            LAUNCH: state_nx = WAIT;
            WAIT: begin
                if (layer_done[k]) begin
                    if (k == K_LAST) begin
                        state_nx = FINISH;
                    end else begin
                        state_nx = LAUNCH;
                        k_nx     = k + 1'b1;
                    end
                end else if (timeout) begin
                    state_nx = FINISH;
                end
            end
            FINISH: begin
                state_nx = DONE;
                err_nx   = mismatch || wdog_flag;
                pred_nx  = err_nx ? PRED_ERR
                                  : {{(PRED_W-4){1'b0}}, best_idx};
            end
            default: state_nx = IDLE;
        endcase
        if (state_nx == LAUNCH) begin
            layer_start_nx = NUM_LAYERS'(1) << k_nx;
            done_nx        = 1'b0;
            err_nx         = 1'b0;
        end
        if (state_nx == DONE)
            done_nx = 1'b1;
        busy_nx = (state_nx == LAUNCH) || (state_nx == WAIT)
               || (state_nx == FINISH);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= IDLE;
            k                <= '0;
            layer_start      <= '0;
            busy             <= 1'b0;
            done             <= 1'b0;
            err              <= 1'b0;
            final_prediction <= '0;
        end else begin
            state            <= state_nx;
            k                <= k_nx;
            layer_start      <= layer_start_nx;
            busy             <= busy_nx;
            done             <= done_nx;
            err              <= err_nx;
            final_prediction <= pred_nx;
        end
    end

endmodule

// File: tb/tb_mnist_layer_sequencer.sv
// Directed self-checking bench for mnist_layer_sequencer.
// Watchdog scenario runs only when SEQ_WATCHDOG_EN is defined.
module tb_mnist_layer_sequencer;

    localparam int NL = 3;
    localparam int NC = 10;
    localparam int DW = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic [NL-1:0] layer_start;
    logic [NL-1:0] layer_done = '0;
    logic score_valid = 1'b0;
    logic signed [DW-1:0] score_data = '0;
    logic busy, done, err;
    logic [15:0] final_prediction;

    int passed = 0;
    int total = 0;
    int ls_cnt [NL] = '{0, 0, 0};
    logic signed [DW-1:0] sc [16];

    always #5 clk = ~clk;

    always @(negedge clk)
        for (int i = 0; i < NL; i++)
            if (layer_start[i]) ls_cnt[i]++;

    mnist_layer_sequencer #(
        .NUM_LAYERS (NL),
        .NUM_CLASSES(NC),
        .DATA_W     (DW),
        .WDOG_CYC   (50)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .start           (start),
        .layer_start     (layer_start),
        .layer_done      (layer_done),
        .score_valid     (score_valid),
        .score_data      (score_data),
        .busy            (busy),
        .done            (done),
        .final_prediction(final_prediction),
        .err             (err)
    );

    // Full 3-layer run; the last score coincides with the last layer_done.
    task automatic run_seq(input string name, input int d0, input int d1,
                           input bit noise, input int nsc,
                           input logic [15:0] exp_pred, input logic exp_err);
        int dly [2];
        int base [NL];
        logic [NL-1:0] exp_ls;
        dly[0] = d0;
        dly[1] = d1;
        for (int i = 0; i < NL; i++) base[i] = ls_cnt[i];
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        total++;
        if (layer_start !== 3'b001 || done !== 1'b0 || busy !== 1'b1)
            $display("FAIL %s launch0: ls=%b done=%b busy=%b, want 001/0/1",
                     name, layer_start, done, busy);
        else passed++;
        for (int k = 0; k < 2; k++) begin
            for (int c = 1; c <= dly[k]; c++) begin
                @(negedge clk);
                if (noise && k == 0 && c < dly[k]) begin
                    start = (c == 1);
                    layer_done[2] = (c == 2);
                    score_valid = (c <= 3);
                    score_data = 16'sd500;
                end else begin
                    start = 1'b0;
                    layer_done[2] = 1'b0;
                    score_valid = 1'b0;
                end
                if (c == dly[k]) layer_done[k] = 1'b1;
            end
            @(negedge clk);
            layer_done = '0;
            exp_ls = 3'b010 << k;
            total++;
            if (layer_start !== exp_ls)
                $display("FAIL %s launch%0d: ls=%b, want %b",
                         name, k + 1, layer_start, exp_ls);
            else passed++;
        end
        for (int i = 0; i < nsc; i++) begin
            @(negedge clk);
            score_valid = 1'b1;
            score_data = sc[i];
            layer_done[2] = (i == nsc - 1);
        end
        @(negedge clk);
        score_valid = 1'b0;
        layer_done = '0;
        total++;
        if (done !== 1'b0 || busy !== 1'b1)
            $display("FAIL %s finish: done=%b busy=%b, want 0/1",
                     name, done, busy);
        else passed++;
        @(negedge clk);
        total++;
        if (done !== 1'b1 || busy !== 1'b0)
            $display("FAIL %s done: done=%b busy=%b, want 1/0",
                     name, done, busy);
        else passed++;
        total++;
        if (final_prediction !== exp_pred || err !== exp_err)
            $display("FAIL %s result: pred=%h err=%b, want %h/%b",
                     name, final_prediction, err, exp_pred, exp_err);
        else passed++;
        total++;
        if (ls_cnt[0] - base[0] != 1 || ls_cnt[1] - base[1] != 1
            || ls_cnt[2] - base[2] != 1)
            $display("FAIL %s pulses: %0d/%0d/%0d, want 1/1/1", name,
                     ls_cnt[0] - base[0], ls_cnt[1] - base[1],
                     ls_cnt[2] - base[2]);
        else passed++;
    endtask

    task automatic load_nominal();
        sc[0] = 3;  sc[1] = -2; sc[2] = 9; sc[3] = 9; sc[4] = 1;
        sc[5] = 0;  sc[6] = -5; sc[7] = 2; sc[8] = 8; sc[9] = 4;
        sc[10] = 20;
    endtask

    task automatic test_reset();
        bit bad;
        repeat (10) @(negedge clk);
        total++;
        if (layer_start !== '0 || busy !== 1'b0 || done !== 1'b0
            || final_prediction !== 16'h0 || err !== 1'b0)
            $display("FAIL reset_vals: ls=%b busy=%b done=%b pred=%h err=%b",
                     layer_start, busy, done, final_prediction, err);
        else passed++;
        rst_n = 1'b1;
    endtask

    task automatic test_reset_mid_wait();
        bit bad;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if (busy !== 1'b1)
            $display("FAIL mid_wait_pre: busy=%b, want 1", busy);
        else passed++;
        #2 rst_n = 1'b0;
        #1;
        total++;
        if (busy !== 1'b0 || done !== 1'b0 || layer_start !== '0)
            $display("FAIL mid_wait_rst: busy=%b done=%b ls=%b, want 0/0/0",
                     busy, done, layer_start);
        else passed++;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        layer_done = 3'b001;
        bad = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            layer_done = '0;
            if (layer_start !== '0 || busy !== 1'b0) bad = 1'b1;
        end
        total++;
        if (bad)
            $display("FAIL post_rst_quiet: activity=1, want 0");
        else passed++;
    endtask

    task automatic test_nominal();
        load_nominal();
        run_seq("nominal", 5, 7, 1'b0, 10, 16'h0002, 1'b0);
    endtask

    task automatic test_negative_restart();
        for (int i = 0; i < 16; i++) sc[i] = (i == 7) ? -16'sd1 : -16'sd100;
        total++;
        if (done !== 1'b1)
            $display("FAIL restart_pre: done=%b, want 1", done);
        else passed++;
        run_seq("negative", 3, 2, 1'b0, 10, 16'h0007, 1'b0);
    endtask

    task automatic test_noise();
        load_nominal();
        run_seq("noise", 5, 7, 1'b1, 10, 16'h0002, 1'b0);
    endtask

    task automatic test_count_errors();
        load_nominal();
        run_seq("short9", 2, 3, 1'b0, 9, 16'hFFFF, 1'b1);
        run_seq("long11", 2, 3, 1'b0, 11, 16'hFFFF, 1'b1);
        run_seq("recover", 2, 2, 1'b0, 10, 16'h0002, 1'b0);
    endtask

`ifdef SEQ_WATCHDOG_EN
    task automatic test_watchdog();
        int base2;
        int cyc;
        base2 = ls_cnt[2];
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        layer_done = 3'b001;
        @(negedge clk);
        layer_done = '0;
        cyc = 0;
        while (done !== 1'b1 && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        total++;
        if (cyc != 52)
            $display("FAIL wdog_latency: cycles=%0d, want 52", cyc);
        else passed++;
        total++;
        if (done !== 1'b1 || err !== 1'b1 || final_prediction !== 16'hFFFF)
            $display("FAIL wdog_result: done=%b err=%b pred=%h, want 1/1/ffff",
                     done, err, final_prediction);
        else passed++;
        repeat (5) @(negedge clk);
        total++;
        if (ls_cnt[2] != base2)
            $display("FAIL wdog_no_launch2: pulses=%0d, want 0",
                     ls_cnt[2] - base2);
        else passed++;
    endtask
`endif

    initial begin
        test_reset();
        test_nominal();
        test_negative_restart();
        test_noise();
        test_count_errors();
`ifdef SEQ_WATCHDOG_EN
        test_watchdog();
`endif
        test_reset_mid_wait();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
